// File: rtl/adc_trigger_capture.sv
// Single-channel trigger capture behind the AD7928 controller: channel filter, decimation,
// pre-trigger circular buffer and trigger-aligned readout.
module adc_trigger_capture #(
  parameter int DW = 12,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [2:0]    in_addr,
  input  logic [DW-1:0] in_data,
  input  logic [2:0]    ch_sel,
  input  logic [7:0]    dec,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_edge,
  input  logic [AW-1:0] pre_len,
  input  logic          arm,
  input  logic          abort,
  input  logic          force_trig,
  input  logic          rd_en,
  output logic          busy,
  output logic          armed,
  output logic          done,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_last,
  output logic [2:0]    dbg_state
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_W  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] LAST_IDX = {1'b0, {AW{1'b1}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Handshakes: in_valid qualifies in_addr/in_data for exactly one cycle and cannot be
  // stalled; rd_en is a request whose rd_data/rd_valid answer arrives one cycle later.
  logic [2:0]    r_state;
  logic [2:0]    r_ch_sel;
  logic [7:0]    r_dec;
  logic [DW-1:0] r_level;
  logic          r_edge;
  logic [AW-1:0] r_pre_len;
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_start;
  logic [AW:0]   r_idx;
  logic [7:0]    r_dec_cnt;
  logic [AW-1:0] r_pre_cnt;
  logic [AW:0]   r_post_cnt;
  logic          r_prev_valid;
  logic [DW-1:0] r_prev;
  logic          r_force_pend;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_valid;
  logic          r_rd_last;
  logic [DW-1:0] r_mem [DEPTH];

  logic          w_capturing;
  logic          w_accept;
  logic          w_store;
  logic          w_level_hit;
  logic          w_trigger;
  logic [AW:0]   w_post_target;
  logic [AW:0]   w_post_next;
  logic [AW-1:0] w_pre_next;
  logic [AW-1:0] w_rd_addr;
  logic          w_rd_fire;

  assign w_capturing   = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
  assign w_accept      = in_valid && (in_addr == r_ch_sel) && w_capturing;
  assign w_store       = w_accept && (r_dec_cnt == 8'd0);
  assign w_level_hit   = r_prev_valid &&
                         (r_edge ? ((r_prev > r_level) && (in_data <= r_level))
                                 : ((r_prev < r_level) && (in_data >= r_level)));
  assign w_trigger     = w_store && (r_state == S_ARMED) && (r_force_pend || w_level_hit);
  assign w_post_target = DEPTH_W - {1'b0, r_pre_len};
  assign w_post_next   = r_post_cnt + (AW+1)'(1);
  assign w_pre_next    = r_pre_cnt + AW'(1);
  assign w_rd_addr     = r_start + r_idx[AW-1:0];
  assign w_rd_fire     = rd_en && (r_state == S_DONE) && !r_idx[AW];

  assign busy      = w_capturing;
  assign armed     = (r_state == S_ARMED);
  assign done      = (r_state == S_DONE);
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_last;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (w_store && !abort) r_mem[r_wp] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ch_sel     <= '0;
      r_dec        <= '0;
      r_level      <= '0;
      r_edge       <= 1'b0;
      r_pre_len    <= '0;
      r_wp         <= '0;
      r_start      <= '0;
      r_idx        <= '0;
      r_dec_cnt    <= '0;
      r_pre_cnt    <= '0;
      r_post_cnt   <= '0;
      r_prev_valid <= 1'b0;
      r_prev       <= '0;
      r_force_pend <= 1'b0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_last    <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      r_rd_last  <= w_rd_fire && (r_idx == LAST_IDX);
      if (w_rd_fire) begin
        r_rd_data <= r_mem[w_rd_addr];
        r_idx     <= r_idx + (AW+1)'(1);
      end

      if (abort) begin
        r_state      <= S_IDLE;
        r_force_pend <= 1'b0;
      end else if (arm && ((r_state == S_IDLE) || (r_state == S_DONE))) begin
        r_ch_sel     <= ch_sel;
        r_dec        <= dec;
        r_level      <= trig_level;
        r_edge       <= trig_edge;
        r_pre_len    <= pre_len;
        r_dec_cnt    <= '0;
        r_pre_cnt    <= '0;
        r_post_cnt   <= '0;
        r_idx        <= '0;
        r_prev_valid <= 1'b0;
        r_force_pend <= 1'b0;
        r_state      <= (pre_len != '0) ? S_PRE : S_ARMED;
      end else begin
        if (w_accept) r_dec_cnt <= (r_dec_cnt == r_dec) ? 8'd0 : r_dec_cnt + 8'd1;
        if (w_store) begin
          r_wp <= r_wp + AW'(1);
          if (r_state != S_POST) begin
            r_prev       <= in_data;
            r_prev_valid <= 1'b1;
          end
        end
        case (r_state)
          S_PRE: begin
            if (w_store) begin
              r_pre_cnt <= w_pre_next;
              if (w_pre_next == r_pre_len) r_state <= S_ARMED;
            end
          end
          S_ARMED: begin
            // The trigger sample is post sample 1, so a one-sample post window ends here.
            if (w_trigger) begin
              r_force_pend <= 1'b0;
              r_start      <= r_wp - r_pre_len;
              r_post_cnt   <= (AW+1)'(1);
              r_state      <= (w_post_target == (AW+1)'(1)) ? S_DONE : S_POST;
            end else if (force_trig) begin
              r_force_pend <= 1'b1;
            end
          end
          S_POST: begin
            if (w_store) begin
              r_post_cnt <= w_post_next;
              if (w_post_next == w_post_target) r_state <= S_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
